// File: rtl/test_seq_ctrl.sv
// test_seq_ctrl: sequences NUM_TESTS test channels one at a time.
// Each test is enabled, watched for done or timeout, and then held in
// reset for a gap before the next one. Per-test fail and timeout results
// are collected and an overall pass flag is reported when the sequence ends.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; starts a sequence from IDLE or DONE
//   skip_mask         per-test exclusion, captured when start is accepted
//   test_done/fail    per-test completion level and failure flag
//   test_en           one-hot-or-zero enable of the running test
//   test_rst_n        active-low reset to the tests (released only in RUN)
//   busy, cur_test    sequence in progress, index of current test
//   all_done, pass    sequence finished, no failures recorded
//   fail_mask         per-test failure record
//   timeout_mask      per-test timeout record
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | cur_test enabled, cycle counter running
// GAP   | tests held in reset for GAP_CYCLES cycles
// DONE  | results held until the next start
module test_seq_ctrl #(
    parameter int NUM_TESTS      = 25,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int GAP_CYCLES     = 5,
    parameter int STOP_ON_FAIL   = 1,
    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] skip_mask,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_fail,
    output logic [NUM_TESTS-1:0] test_en,
    output logic                 test_rst_n,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_test,
    output logic                 all_done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_TESTS-1:0] skip_q, skip_d;
    logic [NUM_TESTS-1:0] fail_q, fail_d;
    logic [NUM_TESTS-1:0] to_q, to_d;
    logic [NUM_TESTS-1:0] en_q, en_d;
    logic                 trst_n_q, trst_n_d;
    logic                 busy_q, busy_d;
    logic                 all_done_q, all_done_d;
    logic                 pass_q, pass_d;
    logic [IDX_W:0]       nxt;

    // Lowest non-skipped index at or above 'from'; MSB flags that one exists.
    function automatic logic [IDX_W:0] find_next(input logic [NUM_TESTS-1:0] skip,
                                                 input int from);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (i >= from && !skip[i]) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        skip_d  = skip_q;
        fail_d  = fail_q;
        to_d    = to_q;
        nxt     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    skip_d = skip_mask;
                    fail_d = '0;
                    to_d   = '0;
                    nxt    = find_next(skip_mask, 0);
                    cnt_d  = '0;
                    if (nxt[IDX_W]) begin
                        state_d = S_RUN;
                        cur_d   = nxt[IDX_W-1:0];
                    end else begin
                        state_d = S_DONE;
                        cur_d   = '0;
                    end
                end
            end
            S_RUN: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (test_done[cur_q]) begin
                    fail_d[cur_q] = test_fail[cur_q];
                    state_d       = S_GAP;
                    gap_d         = GAP_INIT;
                end else if (cnt_q == TO_LIM) begin
                    fail_d[cur_q] = 1'b1;
                    to_d[cur_q]   = 1'b1;
                    state_d       = S_GAP;
                    gap_d         = GAP_INIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    nxt = find_next(skip_q, int'(cur_q) + 1);
                    if (((STOP_ON_FAIL != 0) && (fail_q != '0)) || !nxt[IDX_W]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        cur_d   = nxt[IDX_W-1:0];
                        cnt_d   = '0;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        en_d = '0;
        if (state_d == S_RUN) en_d[cur_d] = 1'b1;
        trst_n_d   = (state_d == S_RUN);
        busy_d     = (state_d == S_RUN) || (state_d == S_GAP);
        all_done_d = (state_d == S_DONE);
        pass_d     = (state_d == S_DONE) && (fail_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            skip_q     <= '0;
            fail_q     <= '0;
            to_q       <= '0;
            en_q       <= '0;
            trst_n_q   <= 1'b0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            skip_q     <= skip_d;
            fail_q     <= fail_d;
            to_q       <= to_d;
            en_q       <= en_d;
            trst_n_q   <= trst_n_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
            pass_q     <= pass_d;
        end
    end

    assign test_en      = en_q;
    assign test_rst_n   = trst_n_q;
    assign busy         = busy_q;
    assign cur_test     = cur_q;
    assign all_done     = all_done_q;
    assign pass         = pass_q;
    assign fail_mask    = fail_q;
    assign timeout_mask = to_q;

endmodule
